uart_rx: RTL

//   UART receiver (8N1, LSB first) for the rxd side of the system top. Recovers bytes from the

---
 rtl/uart_defs_pkg.sv | 17 +
 rtl/uart_rx_fifo.sv | 62 ++++++
 rtl/uart_rx.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: baud divider computation and receiver FSM state encodings.
`timescale 1ns/1ps
package uart_defs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

  function automatic int bit_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with a registered head byte and registered valid flag.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head,
  output logic       head_valid
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_next, rd_next;
  logic        wr_en, rd_en;
  logic [7:0]  head_next;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = pop & ~empty;
  // A pop frees the slot on the same edge, so a full FIFO still accepts a push then.
  assign wr_en = push & (~full | rd_en);

  assign wr_next = wr_ptr + {{AW{1'b0}}, wr_en};
  assign rd_next = rd_ptr + {{AW{1'b0}}, rd_en};

  always_comb begin
    head_next = 8'h00;
    if (rd_next != wr_next) begin
      if (wr_en && (rd_next[AW-1:0] == wr_ptr[AW-1:0]))
        head_next = push_data;
      else
        head_next = mem[rd_next[AW-1:0]];
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      head       <= 8'h00;
      head_valid <= 1'b0;
    end else begin
      wr_ptr     <= wr_next;
      rd_ptr     <= rd_next;
      head       <= head_next;
      head_valid <= (rd_next != wr_next);
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: line synchroniser, mid-bit sampling FSM and receive FIFO.
`timescale 1ns/1ps
module uart_rx
  import uart_defs_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd_line,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  // state   | meaning
  // IDLE    | line idle, waiting for a falling edge
  // START   | half a bit in, confirm start bit is still low
  // DATA    | sample 8 data bits at bit centres, LSB first
  // STOP    | sample stop bit; high pushes the byte, low flags a framing error
  // BREAK   | line held low after a framing error, wait for it to go high

  localparam int BIT_DIV = bit_div(CLK_HZ, BAUD);
  localparam int CW      = $clog2(BIT_DIV);
  localparam logic [CW-1:0] CNT_FULL = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(BIT_DIV / 2 - 1);

  uart_state_t   state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          sync1, rxd_s, rxd_prev;
  logic          push_q;
  logic [7:0]    push_byte;
  logic          fifo_full, fifo_empty, pop;

  assign pop = rx_valid & rx_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1    <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      sync1    <= rxd_line;
      rxd_s    <= sync1;
      rxd_prev <= rxd_s;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      push_q    <= 1'b0;
      push_byte <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      push_q    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (rxd_prev && !rxd_s)
            state <= ST_START;
        end
        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rxd_s) begin
              state   <= ST_DATA;
              bit_idx <= 3'd0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt     <= '0;
            shreg   <= {rxd_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7)
              state <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (rxd_s) begin
              push_q    <= 1'b1;
              push_byte <= shreg;
              state     <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          cnt <= '0;
          if (rxd_s)
            state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // A byte is lost only if no slot frees up on the edge it is written.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      overrun <= 1'b0;
    else
      overrun <= push_q & fifo_full & ~pop;
  end

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push_q),
    .push_data  (push_byte),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (rx_data),
    .head_valid (rx_valid)
  );

  logic unused_empty;
  assign unused_empty = fifo_empty;

endmodule
